// File: rtl/fetch_unit.sv
// fetch_unit: single-entry instruction fetch stage with redirect, stall and handoff counting.
// Memory read is asynchronous; the output register is the only pipeline stage.
module fetch_unit #(
    parameter int          DATA_WIDTH = 32,
    parameter int          MEM_DEPTH  = 1024,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    localparam int         AW         = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [AW-1:0]         iaddr,
    input  logic [DATA_WIDTH-1:0] idata,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [31:0]           out_pc,
    output logic                  misalign_err,
    output logic [31:0]           fetch_count
);
    logic [31:0]           r_pc;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_instr;
    logic [31:0]           r_out_pc;
    logic                  r_misalign;
    logic [31:0]           r_count;
    logic                  w_advance;
    logic                  w_handoff;
    assign w_advance    = !r_out_valid || out_ready;
    assign w_handoff    = r_out_valid && out_ready;
    assign iaddr        = r_pc[AW+1:2];
    assign out_valid    = r_out_valid;
    assign out_instr    = r_out_instr;
    assign out_pc       = r_out_pc;
    assign misalign_err = r_misalign;
    assign fetch_count  = r_count;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_out_valid <= 1'b0;
            r_out_instr <= DATA_WIDTH'(32'h0000_0013);
            r_out_pc    <= 32'h0;
            r_misalign  <= 1'b0;
            r_count     <= 32'h0;
        end else begin
            // a flushed instruction still counts: decode accepted it this edge
            r_count <= r_count + {31'h0, w_handoff};
            if (redirect_valid) begin
                r_pc        <= {redirect_pc[31:2], 2'b00};
                r_out_valid <= 1'b0;
                r_misalign  <= r_misalign || (redirect_pc[1:0] != 2'b00);
            end else if (w_advance) begin
                r_pc        <= r_pc + 32'd4;
                r_out_valid <= 1'b1;
                r_out_instr <= idata;
                r_out_pc    <= r_pc;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit with a 1024-word and a 16-word memory.
module tb_fetch_unit;
    logic        clk;
    logic        rst_a, rst_b;
    logic [9:0]  iaddr_a;
    logic [3:0]  iaddr_b;
    logic [31:0] idata_a, idata_b;
    logic        rv_a, rv_b, rdy_a, rdy_b;
    logic [31:0] rpc_a, rpc_b;
    logic        ov_a, ov_b, mis_a, mis_b;
    logic [31:0] oi_a, oi_b, opc_a, opc_b, cnt_a, cnt_b;
    int          n_chk = 0;
    int          n_err = 0;

    assign idata_a = 32'h1000_0000 + 32'(iaddr_a);
    assign idata_b = 32'h1000_0000 + 32'(iaddr_b);

    fetch_unit u_a (
        .clk(clk), .rst(rst_a), .iaddr(iaddr_a), .idata(idata_a),
        .redirect_valid(rv_a), .redirect_pc(rpc_a), .out_valid(ov_a),
        .out_ready(rdy_a), .out_instr(oi_a), .out_pc(opc_a),
        .misalign_err(mis_a), .fetch_count(cnt_a)
    );

    fetch_unit #(.MEM_DEPTH(16)) u_b (
        .clk(clk), .rst(rst_b), .iaddr(iaddr_b), .idata(idata_b),
        .redirect_valid(rv_b), .redirect_pc(rpc_b), .out_valid(ov_b),
        .out_ready(rdy_b), .out_instr(oi_b), .out_pc(opc_b),
        .misalign_err(mis_b), .fetch_count(cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        rv_a = 1'b0; rv_b = 1'b0; rpc_a = 32'h0; rpc_b = 32'h0;
        rdy_a = 1'b1; rdy_b = 1'b1;
        #3;
        chk("rst_valid", 32'(ov_a), 32'h0);
        chk("rst_instr", oi_a, 32'h13);
        chk("rst_pc", opc_a, 32'h0);
        chk("rst_count", cnt_a, 32'h0);
        chk("rst_iaddr", 32'(iaddr_a), 32'h0);
        chk("rst_mis", 32'(mis_a), 32'h0);
        #9 rst_a = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("seq_valid", 32'(ov_a), 32'h1);
            chk("seq_pc", opc_a, 32'(4 * (k - 1)));
            chk("seq_instr", oi_a, 32'h1000_0000 + 32'(k - 1));
            chk("seq_count", cnt_a, 32'(k - 1));
        end
        tick();
        chk("seq_count5", cnt_a, 32'd5);
        // fresh start, then stall while word 2 is on the output
        #2 rst_a = 1'b1;
        #1 chk("rst2_count", cnt_a, 32'h0);
        rst_a = 1'b0;
        tick(); tick(); tick();
        chk("pre_stall_pc", opc_a, 32'h8);
        rdy_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_pc", opc_a, 32'h8);
            chk("stall_instr", oi_a, 32'h1000_0002);
            chk("stall_iaddr", 32'(iaddr_a), 32'd3);
            chk("stall_count", cnt_a, 32'd2);
            chk("stall_valid", 32'(ov_a), 32'h1);
        end
        rdy_a = 1'b1;
        tick();
        chk("resume_pc", opc_a, 32'hC);
        chk("resume_count", cnt_a, 32'd3);
        rv_a = 1'b1; rpc_a = 32'h40;
        tick();
        rv_a = 1'b0;
        chk("redir_bubble", 32'(ov_a), 32'h0);
        chk("redir_pc_hold", opc_a, 32'hC);
        chk("redir_count", cnt_a, 32'd4);
        chk("redir_iaddr", 32'(iaddr_a), 32'h10);
        tick();
        chk("redir_valid", 32'(ov_a), 32'h1);
        chk("redir_tgt_pc", opc_a, 32'h40);
        chk("redir_tgt_instr", oi_a, 32'h1000_0010);
        chk("redir_mis", 32'(mis_a), 32'h0);
        chk("redir_count2", cnt_a, 32'd4);
        tick();
        chk("post_redir_pc", opc_a, 32'h44);
        chk("post_redir_count", cnt_a, 32'd5);
        rv_a = 1'b1; rpc_a = 32'h42;
        tick();
        chk("mis_set", 32'(mis_a), 32'h1);
        chk("mis_iaddr", 32'(iaddr_a), 32'h10);
        chk("mis_count", cnt_a, 32'd6);
        rpc_a = 32'h80;
        tick();
        rv_a = 1'b0;
        chk("mis_sticky", 32'(mis_a), 32'h1);
        chk("mis_iaddr2", 32'(iaddr_a), 32'h20);
        tick();
        chk("mis_tgt_pc", opc_a, 32'h80);
        chk("mis_tgt_instr", oi_a, 32'h1000_0020);
        chk("mis_sticky2", 32'(mis_a), 32'h1);
        rdy_a = 1'b0;
        tick();
        chk("hold_pc", opc_a, 32'h80);
        chk("hold_count", cnt_a, 32'd6);
        #2 rst_a = 1'b1;
        #1;
        chk("arst_valid", 32'(ov_a), 32'h0);
        chk("arst_instr", oi_a, 32'h13);
        chk("arst_count", cnt_a, 32'h0);
        chk("arst_mis", 32'(mis_a), 32'h0);
        chk("arst_iaddr", 32'(iaddr_a), 32'h0);
        // 16-word memory: address wrap and 32-bit pc wrap
        rst_b = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 15) chk("wrap_iaddr15", 32'(iaddr_b), 32'd15);
            if (k == 16) begin
                chk("wrap_iaddr0", 32'(iaddr_b), 32'd0);
                chk("wrap_pc3c", opc_b, 32'h3C);
                chk("wrap_instr15", oi_b, 32'h1000_000F);
            end
        end
        chk("wrap_pc40", opc_b, 32'h40);
        chk("wrap_instr0", oi_b, 32'h1000_0000);
        chk("wrap_count", cnt_b, 32'd16);
        rv_b = 1'b1; rpc_b = 32'hFFFF_FFFC;
        tick();
        rv_b = 1'b0;
        chk("top_bubble", 32'(ov_b), 32'h0);
        chk("top_iaddr", 32'(iaddr_b), 32'd15);
        tick();
        chk("top_pc", opc_b, 32'hFFFF_FFFC);
        chk("top_instr", oi_b, 32'h1000_000F);
        chk("top_iaddr0", 32'(iaddr_b), 32'd0);
        tick();
        chk("top_wrap_pc", opc_b, 32'h0);
        chk("top_wrap_instr", oi_b, 32'h1000_0000);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
